// File: rtl/linear_router_node.sv
// Three-port node of the one-dimensional interconnect: buffered left/right/local inputs,
// destination-routed single-word packets, per-output round-robin arbitration and drop counting.
module linear_router_node #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NODE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  shiftInCLK,
  input  logic                  shiftInRST,
  input  logic [DATA_WIDTH-1:0] shiftInLeftData,
  input  logic                  shiftInLeftCS,
  output logic                  shiftInLeftReady,
  input  logic [DATA_WIDTH-1:0] shiftInRightData,
  input  logic                  shiftInRightCS,
  output logic                  shiftInRightReady,
  input  logic [DATA_WIDTH-1:0] shiftInData,
  input  logic                  shiftInCS,
  output logic                  shiftInReady,
  output logic [DATA_WIDTH-1:0] shiftOutLeftData,
  output logic                  shiftOutLeftCS,
  input  logic                  shiftOutLeftReady,
  output logic [DATA_WIDTH-1:0] shiftOutRightData,
  output logic                  shiftOutRightCS,
  input  logic                  shiftOutRightReady,
  output logic [DATA_WIDTH-1:0] shiftOutData,
  output logic                  shiftOutCS,
  input  logic                  shiftOutReady,
  output logic [7:0]            dropCount,
  output logic                  dropPulse
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] NODE = ADDR_WIDTH'(NODE_ADDR);
  localparam logic [1:0] P_LEFT = 2'd0, P_RIGHT = 2'd1, P_LOCAL = 2'd2, P_DROP = 2'd3;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] offset);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, offset};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Index 0 = left, 1 = right, 2 = local for both inputs and outputs.
  logic [DATA_WIDTH-1:0] in_data [3];
  logic [2:0]            in_cs, out_ready, full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] mem [3][FIFO_DEPTH];
  logic [PW:0]           wr_ptr [3];
  logic [PW:0]           rd_ptr [3];
  logic [DATA_WIDTH-1:0] head [3];
  logic [ADDR_WIDTH-1:0] dest [3];
  logic [1:0]            route [3];
  logic [2:0]            req [3];
  logic [2:0]            gnt_valid;
  logic [1:0]            gnt_idx [3];
  logic [1:0]            rr_ptr [3];
  logic [DATA_WIDTH-1:0] out_data [3];
  logic [2:0]            out_cs;
  logic [8:0]            cnt_next;

  assign in_data[0] = shiftInLeftData;
  assign in_data[1] = shiftInRightData;
  assign in_data[2] = shiftInData;
  assign in_cs      = {shiftInCS, shiftInRightCS, shiftInLeftCS};
  assign out_ready  = {shiftOutReady, shiftOutRightReady, shiftOutLeftReady};

  assign shiftInLeftReady  = ~full[0] & ~shiftInRST;
  assign shiftInRightReady = ~full[1] & ~shiftInRST;
  assign shiftInReady      = ~full[2] & ~shiftInRST;

  assign shiftOutLeftData  = out_data[0];
  assign shiftOutRightData = out_data[1];
  assign shiftOutData      = out_data[2];
  assign shiftOutLeftCS    = out_cs[0];
  assign shiftOutRightCS   = out_cs[1];
  assign shiftOutCS        = out_cs[2];

  always_comb begin
    full = '0;
    empty = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < 3; i++) begin
      full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) && (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      push[i]  = in_cs[i] & ~full[i];
      head[i]  = mem[i][rd_ptr[i][PW-1:0]];
      dest[i]  = head[i][DATA_WIDTH-1 -: ADDR_WIDTH];
      // A word heading back toward the side it arrived from is misrouted.
      if (dest[i] == NODE)     route[i] = P_LOCAL;
      else if (dest[i] > NODE) route[i] = (i == 1) ? P_DROP : P_RIGHT;
      else                     route[i] = (i == 0) ? P_DROP : P_LEFT;
      drop[i] = ~empty[i] && (route[i] == P_DROP);
    end
  end

  always_comb begin
    logic [1:0] cand;
    cand = '0;
    gnt_valid = '0;
    pop = drop;
    for (int o = 0; o < 3; o++) begin
      gnt_idx[o] = '0;
      for (int i = 0; i < 3; i++) req[o][i] = ~empty[i] && (route[i] == 2'(o));
      // A full output register whose consumer stalls receives no grant.
      if (!out_cs[o] || out_ready[o]) begin
        for (int k = 0; k < 3; k++) begin
          cand = rr_idx(rr_ptr[o], 2'(k));
          if (!gnt_valid[o] && req[o][cand]) begin
            gnt_valid[o] = 1'b1;
            gnt_idx[o]   = cand;
          end
        end
      end
      for (int i = 0; i < 3; i++)
        if (gnt_valid[o] && gnt_idx[o] == 2'(i)) pop[i] = 1'b1;
    end
    cnt_next = {1'b0, dropCount} + 9'(drop[0]) + 9'(drop[1]);
  end

  // Storage carries no reset; pointer reset alone makes every entry stale.
  always_ff @(posedge shiftInCLK) begin
    for (int i = 0; i < 3; i++)
      if (push[i]) mem[i][wr_ptr[i][PW-1:0]] <= in_data[i];
  end

  always_ff @(posedge shiftInCLK or posedge shiftInRST) begin
    if (shiftInRST) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        rr_ptr[i]   <= '0;
        out_data[i] <= '0;
      end
      out_cs    <= '0;
      dropCount <= '0;
      dropPulse <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= wr_ptr[i] + (PW+1)'(push[i]);
        rd_ptr[i] <= rd_ptr[i] + (PW+1)'(pop[i]);
      end
      for (int o = 0; o < 3; o++) begin
        if (gnt_valid[o]) begin
          out_data[o] <= head[gnt_idx[o]];
          out_cs[o]   <= 1'b1;
          rr_ptr[o]   <= rr_idx(gnt_idx[o], 2'd1);
        end else if (out_cs[o] && out_ready[o]) begin
          out_cs[o] <= 1'b0;
        end
      end
      dropCount <= (cnt_next > 9'd255) ? 8'hFF : cnt_next[7:0];
      dropPulse <= |drop;
    end
  end

endmodule

// File: doc/linear_router_node.md
Name: linear_router_node

Overview:
Parametrised next-generation node for the one-dimensional interconnect. It has three ports: left neighbour, right neighbour and local (self). Each input is buffered in a FIFO, and single-word packets are routed by a destination-address field. Each output port has its own round-robin arbiter and CS/Ready backpressure. Misrouted packets are dropped and counted. Nodes chain left-to-right with addresses increasing to the right.

Parameters:
DATA_WIDTH, 32, width of every data word.
ADDR_WIDTH, 4, width of the destination field, held in data bits [DATA_WIDTH-1 -: ADDR_WIDTH].
NODE_ADDR, 0, this node's address (0 .. 2^ADDR_WIDTH-1).
FIFO_DEPTH, 4, entries per input FIFO; power of two, >= 2.

Ports:
shiftInCLK  in  1  clock; all state updates on the rising edge.
shiftInRST  in  1  reset; asynchronous, active-high.
shiftInLeftData  in  DATA_WIDTH  word from left neighbour.
shiftInLeftCS  in  1  left input valid.
shiftInLeftReady  out  1  left FIFO can accept a word.
shiftInRightData / shiftInRightCS / shiftInRightReady  in/in/out  DATA_WIDTH/1/1  right input, same semantics.
shiftInData / shiftInCS / shiftInReady  in/in/out  DATA_WIDTH/1/1  local input, same semantics.
shiftOutLeftData  out  DATA_WIDTH  word to left neighbour.
shiftOutLeftCS  out  1  left output valid.
shiftOutLeftReady  in  1  left neighbour accepts.
shiftOutRightData / shiftOutRightCS / shiftOutRightReady  out/out/in  right output, same semantics.
shiftOutData / shiftOutCS / shiftOutReady  out/out/in  local output, same semantics.
dropCount  out  8  saturating count of dropped misrouted words.
dropPulse  out  1  one-cycle pulse per dropped word.

Behaviour:
- Reset (async assert, sync release):
  - all FIFOs empty;
  - all shiftOut*CS = 0 and shiftOut*Data = 0;
  - all arbiter pointers = 0;
  - dropCount = 0, dropPulse = 0;
  - all shiftIn*Ready = 0 while shiftInRST = 1, and 1 in the first cycle after release.
- Reset mid-operation discards every buffered and in-flight word. No partial state survives.
- Input handshake:
  - Ready = FIFO not full, registered-state based.
  - A word is pushed on an edge where CS & Ready.
  - CS while Ready = 0 is ignored; the sender must hold.
  - A push and a pop on the same FIFO in the same cycle are both legal.
- Routing of the FIFO head word, with dest = head[DATA_WIDTH-1 -: ADDR_WIDTH]:
  - dest == NODE_ADDR → local output.
  - dest > NODE_ADDR → right output.
  - dest < NODE_ADDR → left output.
- Misroute rule:
  - A left-input head with dest < NODE_ADDR is popped without forwarding.
  - A right-input head with dest > NODE_ADDR is popped without forwarding.
  - Each such pop: dropPulse = 1 for the following cycle and dropCount += 1, saturating at 255.
  - The local input never misroutes.
  - At most one drop per input per cycle. Simultaneous drops from left and right add 2, with saturation. dropPulse is still a single 1.
- Arbitration, per output:
  - Requesters are input FIFO heads routed to that output. Indices: 0 = left, 1 = right, 2 = local.
  - The round-robin search starts at the pointer index.
  - On a grant, pointer <= (winner + 1) mod 3. With no grant the pointer holds.
  - Each FIFO is granted to at most one output per cycle. This follows because each head has one destination.
- Output stage: one register per output.
  - It loads the granted word (CS <= 1) when the register is empty (CS = 0) or Ready = 1. The granted FIFO pops on the same edge.
  - If CS = 1 and Ready = 1 with no grant, CS <= 0.
  - If CS = 1 and Ready = 0, Data and CS hold stable. No grant is issued.
- Latency with no contention and downstream Ready = 1:
  - input push at edge N;
  - head visible after edge N;
  - output CS = 1 after edge N+1;
  - i.e. 2 cycles input-to-output.
- Sustained throughput is 1 word/cycle per output.
- Ordering: words from the same input to the same output leave in arrival order.
- Data width: the payload passes through unmodified, header included.

Test Plan:
1. NODE_ADDR=4. After reset, left input 32'h6000_002A with CS for 1 cycle → shiftOutRightData = 32'h6000_002A, CS = 1, exactly 2 cycles after the push edge. Other outputs CS = 0. dropCount = 0.
2. Right input 32'h4000_0049, local input 32'h1000_0059, same cycle → shiftOutData = 32'h4000_0049 and shiftOutLeftData = 32'h1000_0059, both 2 cycles later, no contention.
3. Contention: left 32'h4000_0001, right 32'h4000_0002 and local 32'h4000_0003 pushed together, shiftOutReady = 1 → local output delivers 1, 2, 3 on consecutive cycles (pointer 0 after reset). Repeat immediately → the order remains 1, 2, 3 (pointer has wrapped back to 0).
4. Backpressure: shiftOutRightReady = 0. Push 5 words 32'h8000_0000+i on the left → shiftInLeftReady falls to 0 once FIFO_DEPTH+1 words are held (FIFO plus output register). The output holds 32'h8000_0000 stable. Raising Ready drains the words in order 0..4 on consecutive cycles.
5. Misroute: right input 32'h9000_0000 → no output CS, dropPulse = 1 for one cycle, dropCount = 1. 300 further drops → dropCount saturates at 255.
6. Assert shiftInRST mid-way through scenario 4 → all CS = 0 immediately, Ready = 0 during reset. After release, Ready = 1 and no stale word is ever emitted.
